// File: rtl/pwm_pkg.sv
// Definitions shared between the PWM generator and the ramp sequencer that feeds it.
package pwm_pkg;

    localparam int unsigned DefaultCntW = 20;
    localparam int unsigned DwellW      = 8;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRamp   = 2'd1,
        StSteady = 2'd2
    } ramp_state_e;

endpackage

// File: rtl/pwm_ramp_step.sv
// Saturating one-step move of the high-pulse width towards the effective target.
module pwm_ramp_step
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W = DefaultCntW
) (
    input  logic [CNT_W-1:0] hpw_i,
    input  logic [CNT_W-1:0] target_i,
    input  logic [CNT_W:0]   step_i,
    output logic [CNT_W-1:0] next_hpw_o,
    output logic             at_target_o
);

    logic [CNT_W:0]          hpw_ext;
    logic [CNT_W:0]          tgt_ext;
    logic [CNT_W:0]          sum;
    logic signed [CNT_W+1:0] diff;

    always_comb begin
        hpw_ext     = {1'b0, hpw_i};
        tgt_ext     = {1'b0, target_i};
        sum         = hpw_ext + step_i;
        // One extra sign bit so a large step below zero compares as negative instead of wrapping.
        diff        = $signed({1'b0, hpw_ext}) - $signed({1'b0, step_i});
        at_target_o = (hpw_i == target_i);
        next_hpw_o  = hpw_i;
        if (hpw_i < target_i) begin
            next_hpw_o = (sum > tgt_ext) ? target_i : sum[CNT_W-1:0];
        end else if (hpw_i > target_i) begin
            next_hpw_o = (diff < $signed({1'b0, tgt_ext})) ? target_i : diff[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/pwm_ramp.sv
// Soft-start sequencer: walks the PWM high-pulse width to a target, one step per dwell of
// accepted periods, then stops presenting parameters.
module pwm_ramp
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W  = DefaultCntW,
    parameter int unsigned STEP_W = 8
) (
    input  logic              i_sysclk,
    input  logic              i_arst,
    input  logic              i_start,
    input  logic [CNT_W-1:0]  i_period,
    input  logic [CNT_W-1:0]  i_target_hpw,
    input  logic [STEP_W-1:0] i_step,
    input  logic [DwellW-1:0] i_dwell,
    input  logic              i_pa,
    output logic              o_pv,
    output logic [CNT_W-1:0]  o_period,
    output logic [CNT_W-1:0]  o_hpw,
    output logic              o_busy,
    output logic              o_done
);

    ramp_state_e       state_q, state_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [CNT_W-1:0]  target_q, target_d;
    logic [CNT_W:0]    step_q, step_d;
    logic [DwellW-1:0] dwell_q, dwell_d;
    logic [DwellW-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0]  hpw_q, hpw_d;
    logic              done_q, done_d;

    logic [CNT_W-1:0]  tgt_eff;
    logic [CNT_W:0]    step_eff;
    logic [DwellW-1:0] dwell_eff;
    logic [CNT_W-1:0]  init_hpw;
    logic [DwellW:0]   cnt_inc;
    logic              dwell_hit;
    logic [CNT_W-1:0]  next_hpw;
    logic              at_target;

    // Effective parameters as they would be latched this cycle.
    always_comb begin
        tgt_eff = i_target_hpw;
        if (i_target_hpw == '0) begin
            tgt_eff = {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (i_target_hpw > i_period) begin
            tgt_eff = i_period;
        end
        step_eff = {{(CNT_W+1-STEP_W){1'b0}}, i_step};
        if (i_step == '0) begin
            step_eff = {{CNT_W{1'b0}}, 1'b1};
        end
        dwell_eff = (i_dwell == '0) ? {{(DwellW-1){1'b0}}, 1'b1} : i_dwell;
        init_hpw  = (step_eff > {1'b0, tgt_eff}) ? tgt_eff : step_eff[CNT_W-1:0];
    end

    always_comb begin
        cnt_inc   = {1'b0, cnt_q} + {{DwellW{1'b0}}, 1'b1};
        dwell_hit = (cnt_inc >= {1'b0, dwell_q});
    end

    pwm_ramp_step #(
        .CNT_W (CNT_W)
    ) u_step (
        .hpw_i       (hpw_q),
        .target_i    (target_q),
        .step_i      (step_q),
        .next_hpw_o  (next_hpw),
        .at_target_o (at_target)
    );

    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        target_d = target_q;
        step_d   = step_q;
        dwell_d  = dwell_q;
        cnt_d    = cnt_q;
        hpw_d    = hpw_q;
        done_d   = 1'b0;

        // A start in any state latches parameters and restarts the dwell; it also masks i_pa.
        if (i_start) begin
            period_d = i_period;
            target_d = tgt_eff;
            step_d   = step_eff;
            dwell_d  = dwell_eff;
            cnt_d    = '0;
            state_d  = StRamp;
        end

        case (state_q)
            StIdle: begin
                if (i_start) begin
                    hpw_d = init_hpw;
                end
            end
            StRamp: begin
                if (!i_start && i_pa) begin
                    if (dwell_hit) begin
                        cnt_d = '0;
                        if (at_target) begin
                            done_d  = 1'b1;
                            state_d = StSteady;
                        end else begin
                            hpw_d = next_hpw;
                        end
                    end else begin
                        cnt_d = cnt_inc[DwellW-1:0];
                    end
                end
            end
            StSteady: begin
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_sysclk) begin
        if (i_arst) begin
            state_q  <= StIdle;
            period_q <= '0;
            target_q <= '0;
            step_q   <= '0;
            dwell_q  <= '0;
            cnt_q    <= '0;
            hpw_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            target_q <= target_d;
            step_q   <= step_d;
            dwell_q  <= dwell_d;
            cnt_q    <= cnt_d;
            hpw_q    <= hpw_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        o_pv     = (state_q == StRamp);
        o_busy   = (state_q == StRamp);
        o_period = period_q;
        o_hpw    = hpw_q;
        o_done   = done_q;
    end

endmodule

// File: tb/tb_pwm_ramp.sv
// Scoreboard bench for pwm_ramp: expected accepted widths and done events are queued by the
// stimulus, and a negedge monitor pops and compares them as the DUT presents them.
module tb_pwm_ramp;

    localparam int unsigned CNT_W  = 20;
    localparam int unsigned STEP_W = 8;
    localparam int          GAP    = 100;

    typedef struct {
        bit          is_done;
        logic [31:0] hpw;
        logic [31:0] period;
    } exp_t;

    logic              clk = 1'b0;
    logic              i_arst = 1'b1;
    logic              i_start = 1'b0;
    logic [CNT_W-1:0]  i_period = '0;
    logic [CNT_W-1:0]  i_target_hpw = '0;
    logic [STEP_W-1:0] i_step = '0;
    logic [7:0]        i_dwell = '0;
    logic              i_pa = 1'b0;
    logic              o_pv;
    logic [CNT_W-1:0]  o_period;
    logic [CNT_W-1:0]  o_hpw;
    logic              o_busy;
    logic              o_done;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];

    pwm_ramp #(
        .CNT_W  (CNT_W),
        .STEP_W (STEP_W)
    ) dut (
        .i_sysclk     (clk),
        .i_arst       (i_arst),
        .i_start      (i_start),
        .i_period     (i_period),
        .i_target_hpw (i_target_hpw),
        .i_step       (i_step),
        .i_dwell      (i_dwell),
        .i_pa         (i_pa),
        .o_pv         (o_pv),
        .o_period     (o_period),
        .o_hpw        (o_hpw),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: an accept is i_pa while o_pv is high; a done is the o_done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!i_arst && i_pa && o_pv) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_accept", 32'(o_hpw), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("accept_kind", 32'(0), 32'(e.is_done));
                chk("accept_hpw", 32'(o_hpw), e.hpw);
                chk("accept_period", 32'(o_period), e.period);
            end
        end
        if (!i_arst && o_done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(o_hpw), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("done_kind", 32'(1), 32'(e.is_done));
                chk("done_hpw", 32'(o_hpw), e.hpw);
                chk("done_pv_low", 32'(o_pv), 32'(0));
                chk("done_busy_low", 32'(o_busy), 32'(0));
            end
        end
    end

    task automatic push_acc(input int hpw, input int per);
        exp_t e;
        e.is_done = 1'b0;
        e.hpw     = 32'(hpw);
        e.period  = 32'(per);
        exp_q.push_back(e);
    endtask

    task automatic push_done(input int hpw, input int per);
        exp_t e;
        e.is_done = 1'b1;
        e.hpw     = 32'(hpw);
        e.period  = 32'(per);
        exp_q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_pv"}, 32'(o_pv), 32'(0));
        chk({name, "_period"}, 32'(o_period), 32'(0));
        chk({name, "_hpw"}, 32'(o_hpw), 32'(0));
        chk({name, "_busy"}, 32'(o_busy), 32'(0));
        chk({name, "_done"}, 32'(o_done), 32'(0));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 i_arst = 1'b1;
        @(posedge clk);
        #1 i_arst = 1'b0;
    endtask

    task automatic do_start(input int per, input int tgt, input int stp, input int dw,
                            input bit with_pa);
        @(posedge clk);
        #1;
        i_period     = per[CNT_W-1:0];
        i_target_hpw = tgt[CNT_W-1:0];
        i_step       = stp[STEP_W-1:0];
        i_dwell      = dw[7:0];
        i_start      = 1'b1;
        i_pa         = with_pa;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        i_pa    = 1'b0;
        chk("start_pv", 32'(o_pv), 32'(1));
        chk("start_period", 32'(o_period), 32'(per));
    endtask

    // Generator model: one accept pulse at the end of each period.
    task automatic gen_pa(input int gap);
        repeat (gap - 1) @(posedge clk);
        #1 i_pa = 1'b1;
        @(posedge clk);
        #1 i_pa = 1'b0;
    endtask

    task automatic drain(input string name);
        repeat (3) @(posedge clk);
        chk(name, 32'(exp_q.size()), 32'(0));
        exp_q.delete();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 i_arst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        // Basic ramp up.
        push_acc(10, 100); push_acc(20, 100); push_acc(30, 100); push_done(30, 100);
        do_start(100, 30, 10, 1, 1'b0);
        chk("basic_first_hpw", 32'(o_hpw), 32'(10));
        for (int i = 0; i < 3; i++) gen_pa(GAP);
        drain("basic_drain");
        chk("basic_steady_pv", 32'(o_pv), 32'(0));
        chk("basic_steady_hpw", 32'(o_hpw), 32'(30));

        // Retarget down from STEADY: starts presenting 30, never undershoots 12.
        push_acc(30, 100); push_acc(20, 100); push_acc(12, 100); push_done(12, 100);
        do_start(100, 12, 10, 1, 1'b0);
        for (int i = 0; i < 3; i++) gen_pa(GAP);
        drain("retarget_drain");

        // Overshoot clamps to target.
        do_reset();
        push_acc(10, 100); push_acc(20, 100); push_acc(25, 100); push_done(25, 100);
        do_start(100, 25, 10, 1, 1'b0);
        for (int i = 0; i < 3; i++) gen_pa(GAP);
        drain("overshoot_drain");

        // Target above period clamps to the period.
        do_reset();
        for (int v = 10; v <= 100; v += 10) push_acc(v, 100);
        push_done(100, 100);
        do_start(100, 500, 10, 1, 1'b0);
        for (int i = 0; i < 10; i++) gen_pa(GAP);
        drain("clamp_hi_drain");

        // Step 0 behaves as step 1.
        do_reset();
        push_acc(1, 100); push_acc(2, 100); push_acc(3, 100); push_done(3, 100);
        do_start(100, 3, 0, 1, 1'b0);
        for (int i = 0; i < 3; i++) gen_pa(GAP);
        drain("step0_drain");

        // Target 0 clamps to 1, so the first value is already on target.
        do_reset();
        push_acc(1, 100); push_done(1, 100);
        do_start(100, 0, 5, 1, 1'b0);
        gen_pa(GAP);
        drain("clamp_lo_drain");

        // Dwell of 3: each value presented for three accepts, o_pv held high.
        do_reset();
        for (int i = 0; i < 3; i++) push_acc(5, 100);
        for (int i = 0; i < 3; i++) push_acc(10, 100);
        push_done(10, 100);
        do_start(100, 10, 5, 3, 1'b0);
        for (int i = 0; i < 6; i++) begin
            chk("dwell_pv_high", 32'(o_pv), 32'(1));
            gen_pa(GAP);
        end
        drain("dwell_drain");

        // Collision: start and accept together at hpw=20 with the dwell counter at 1.
        do_reset();
        push_acc(10, 100); push_acc(10, 100); push_acc(20, 100);
        do_start(100, 50, 10, 2, 1'b0);
        for (int i = 0; i < 3; i++) gen_pa(GAP);
        push_acc(20, 100);
        do_start(100, 50, 10, 2, 1'b1);
        chk("collide_hold_hpw", 32'(o_hpw), 32'(20));
        for (int v = 20; v <= 50; v += 10) begin
            push_acc(v, 100); push_acc(v, 100);
        end
        push_done(50, 100);
        for (int i = 0; i < 8; i++) gen_pa(GAP);
        drain("collide_drain");

        // Reset mid-ramp at hpw=20.
        do_reset();
        push_acc(10, 100);
        do_start(100, 50, 10, 1, 1'b0);
        gen_pa(GAP);
        chk("midramp_hpw", 32'(o_hpw), 32'(20));
        do_reset();
        check_reset_outputs("midreset");
        for (int i = 0; i < 2; i++) begin
            gen_pa(10);
            chk("ignored_pa_pv", 32'(o_pv), 32'(0));
            chk("ignored_pa_hpw", 32'(o_hpw), 32'(0));
        end
        drain("midreset_drain");
        // Restart from IDLE begins at min(S, T), not the pre-reset width.
        push_acc(10, 100); push_acc(20, 100); push_done(20, 100);
        do_start(100, 20, 10, 1, 1'b0);
        for (int i = 0; i < 2; i++) gen_pa(GAP);
        drain("restart_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
